// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined CLA adder family: the op encoding and
// the stage-count derivation used to size the pipeline.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Number of pipeline stages for a given operand width and segment width.
    function automatic int nseg(input int width, input int seg);
        return width / seg;
    endfunction

    // Segment width of the original fixed 8-bit CLA adders.
    localparam int CLA8_SEG = 8;

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder. The adder is the slave; the
// producer/consumer side is the master.
interface pipe_adder_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
        input  in_ready, out_valid, f, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
        output in_ready, out_valid, f, cout, ovf
    );

endinterface

// File: rtl/pipe_adder_cla_seg.sv
// Combinational SEG-bit carry-lookahead segment. c_msb is the carry into the
// top bit of the segment, which the final stage needs for signed overflow.
module cla_seg #(
    parameter int SEG = 8
) (
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb,
    input  logic [SEG-1:0] x,
    input  logic [SEG-1:0] y,
    input  logic           ci
);

    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    logic           acc;
    logic           run_p;

    assign g = x & y;
    assign p = x ^ y;

    // Every carry is a flat OR of generate terms gated by the propagate run
    // above them, so no carry depends on another carry.
    always_comb begin
        c     = '0;
        acc   = 1'b0;
        run_p = 1'b0;
        c[0]  = ci;
        for (int i = 0; i < SEG; i++) begin
            acc   = g[i];
            run_p = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc   = acc | (run_p & g[j]);
                run_p = run_p & p[j];
            end
            c[i+1] = acc | (run_p & ci);
        end
    end

    assign s     = p ^ c[SEG-1:0];
    assign co    = c[SEG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG-bit CLA per stage, carry
// registered between stages, operands skewed in and result deskewed out.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input logic          clk,
    input logic          rst,
    pipe_adder_if.slave  bus
);

    localparam int NSEG = nseg(WIDTH, SEG);
    localparam int LAST = NSEG - 1;

    logic             stall;
    logic             advance;
    logic             accept;
    logic             last_valid;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Subtraction is A + ~B + ~cin, so borrow-in maps to an inverted carry-in.
    assign b_eff   = (op_e'(bus.op_sub) == OP_SUB) ? ~bus.b   : bus.b;
    assign cin_eff = (op_e'(bus.op_sub) == OP_SUB) ? ~bus.cin : bus.cin;

    assign stall        = last_valid && !bus.out_ready;
    assign advance      = !stall;
    assign bus.in_ready = !stall && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NSEG; gi++) begin : g_stage
            logic [SEG-1:0]          x;
            logic [SEG-1:0]          y;
            logic [SEG-1:0]          s;
            logic                    ci;
            logic                    co;
            logic                    c_msb;
            logic                    valid_in;
            logic                    valid_reg;
            logic                    carry_reg;
            logic [(gi+1)*SEG-1:0]   res_in;
            logic [(gi+1)*SEG-1:0]   res_reg;

            if (gi == 0) begin : g_head
                assign x        = bus.a[SEG-1:0];
                assign y        = b_eff[SEG-1:0];
                assign ci       = cin_eff;
                assign valid_in = accept;
                assign res_in   = s;
            end else begin : g_body
                assign x        = g_stage[gi-1].g_skew.skew_a_reg[SEG-1:0];
                assign y        = g_stage[gi-1].g_skew.skew_b_reg[SEG-1:0];
                assign ci       = g_stage[gi-1].carry_reg;
                assign valid_in = g_stage[gi-1].valid_reg;
                // Deskew: finished lower segments ride along under the new one.
                assign res_in   = {s, g_stage[gi-1].res_reg};
            end

            // Operand segments not yet consumed; stage gi keeps segments gi+1.. up.
            if (gi < LAST) begin : g_skew
                localparam int SW = WIDTH - (gi + 1) * SEG;
                logic [SW-1:0] skew_a_in;
                logic [SW-1:0] skew_b_in;
                logic [SW-1:0] skew_a_reg;
                logic [SW-1:0] skew_b_reg;

                if (gi == 0) begin : g_src_in
                    assign skew_a_in = bus.a[WIDTH-1:SEG];
                    assign skew_b_in = b_eff[WIDTH-1:SEG];
                end else begin : g_src_prev
                    assign skew_a_in = g_stage[gi-1].g_skew.skew_a_reg[SW+SEG-1:SEG];
                    assign skew_b_in = g_stage[gi-1].g_skew.skew_b_reg[SW+SEG-1:SEG];
                end

                always_ff @(posedge clk) begin
                    if (advance) begin
                        skew_a_reg <= skew_a_in;
                        skew_b_reg <= skew_b_in;
                    end
                end
            end

            cla_seg #(
                .SEG (SEG)
            ) u_cla (
                .s     (s),
                .co    (co),
                .c_msb (c_msb),
                .x     (x),
                .y     (y),
                .ci    (ci)
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    carry_reg <= 1'b0;
                    res_reg   <= '0;
                end else if (advance) begin
                    valid_reg <= valid_in;
                    carry_reg <= co;
                    res_reg   <= res_in;
                end
            end

            if (gi == LAST) begin : g_tail
                logic ovf_reg;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        ovf_reg <= 1'b0;
                    end else if (advance) begin
                        ovf_reg <= c_msb ^ co;
                    end
                end
            end else begin : g_mid
                logic unused_c_msb;
                assign unused_c_msb = c_msb;
            end
        end
    endgenerate

    assign last_valid = g_stage[LAST].valid_reg;

    // Outputs are forced quiet while reset is held, not just after the edge.
    assign bus.out_valid = last_valid && !rst;
    assign bus.f         = rst ? '0 : g_stage[LAST].res_reg;
    assign bus.cout      = g_stage[LAST].carry_reg && !rst;
    assign bus.ovf       = g_stage[LAST].g_tail.ovf_reg && !rst;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: a 32/8 build and an 8/8 build against an
// integer-arithmetic reference model.
module tb_pipe_adder;
    import adder_pkg::*;

    typedef struct packed {
        logic [31:0] f;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(32)) bus32 ();
    pipe_adder_if #(.WIDTH(8))  bus8  ();

    pipe_adder #(.WIDTH(32), .SEG(8)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    pipe_adder #(.WIDTH(8),  .SEG(8)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    // Reference: exact integer add/sub, then wrap, carry and signed-range test.
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        res_t   r;
        longint m, ua, ub, sa, sb, ci, u, s;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        ci = cin ? 1 : 0;
        if (sub) begin
            u      = ua - ub - ci;
            s      = sa - sb - ci;
            r.cout = (u >= 0);
        end else begin
            u      = ua + ub + ci;
            s      = sa + sb + ci;
            r.cout = (u >= m);
        end
        r.f   = 32'(u & (m - 1));
        r.ovf = (s >= m / 2) || (s < -(m / 2));
        return r;
    endfunction

    task automatic op32(input logic [31:0] ai, input logic [31:0] bi, input logic ci,
                        input logic si, output res_t got, output int lat);
        @(negedge clk);
        bus32.a = ai; bus32.b = bi; bus32.cin = ci; bus32.op_sub = si;
        bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        lat = 1;
        while (!bus32.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = '{f: bus32.f, cout: bus32.cout, ovf: bus32.ovf};
        $display("op32 a=%h b=%h cin=%0d sub=%0d -> f=%h cout=%0d ovf=%0d lat=%0d",
                 ai, bi, ci, si, got.f, got.cout, got.ovf, lat);
    endtask

    task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                       input logic si, output res_t got, output int lat);
        @(negedge clk);
        bus8.a = ai; bus8.b = bi; bus8.cin = ci; bus8.op_sub = si;
        bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = '{f: {24'h0, bus8.f}, cout: bus8.cout, ovf: bus8.ovf};
        $display("op8 a=%h b=%h cin=%0d sub=%0d -> f=%h cout=%0d ovf=%0d lat=%0d",
                 ai, bi, ci, si, bus8.f, got.cout, got.ovf, lat);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0/0",
                     bus32.out_valid, bus32.in_ready);
        end
        n_checks++;
        if ({bus32.f, bus32.cout, bus32.ovf} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: f=%h cout=%b ovf=%b, required all 0",
                     bus32.f, bus32.cout, bus32.ovf);
        end
        n_checks++;
        if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_seg8: out_valid=%b in_ready=%b, required 0/0",
                     bus8.out_valid, bus8.in_ready);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: in_ready=%b out_valid=%b, required 1/0",
                     bus32.in_ready, bus32.out_valid);
        end
    endtask

    task automatic test_add;
        res_t got;
        int   lat;
        op32(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, got, lat);
        n_checks++;
        if (got !== '{f: 32'h0000_0100, cout: 1'b0, ovf: 1'b0}) begin
            n_fail++;
            $display("FAIL add_basic: got %h/%b/%b, required 00000100/0/0", got.f, got.cout, got.ovf);
        end
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL add_latency: got %0d cycles, required 4", lat);
        end
    endtask

    task automatic test_carry_ripple;
        res_t got;
        int   lat;
        op32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, got, lat);
        n_checks++;
        if (got !== '{f: 32'h0, cout: 1'b1, ovf: 1'b0}) begin
            n_fail++;
            $display("FAIL ripple_all: got %h/%b/%b, required 00000000/1/0", got.f, got.cout, got.ovf);
        end
        op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, got, lat);
        n_checks++;
        if (got !== '{f: 32'h8000_0000, cout: 1'b0, ovf: 1'b1}) begin
            n_fail++;
            $display("FAIL pos_overflow: got %h/%b/%b, required 80000000/0/1", got.f, got.cout, got.ovf);
        end
    endtask

    task automatic test_sub;
        res_t got;
        int   lat;
        op32(32'd5, 32'd7, 1'b0, 1'b1, got, lat);
        n_checks++;
        if (got !== '{f: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0}) begin
            n_fail++;
            $display("FAIL sub_borrow: got %h/%b/%b, required fffffffe/0/0", got.f, got.cout, got.ovf);
        end
        op32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, got, lat);
        n_checks++;
        if (got !== '{f: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1}) begin
            n_fail++;
            $display("FAIL sub_overflow: got %h/%b/%b, required 7fffffff/1/1", got.f, got.cout, got.ovf);
        end
        op32(32'd10, 32'd3, 1'b1, 1'b1, got, lat);
        n_checks++;
        if (got !== '{f: 32'd6, cout: 1'b1, ovf: 1'b0}) begin
            n_fail++;
            $display("FAIL sub_borrow_in: got %h/%b/%b, required 00000006/1/0", got.f, got.cout, got.ovf);
        end
    endtask

    task automatic test_back_to_back;
        res_t        exp_q[$];
        res_t        exp;
        int          sent = 0, recv = 0, cyc = 0, stray = 0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_f = '0;
        while (recv < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                n_checks++;
                if (bus32.out_valid !== 1'b1 || bus32.f !== prev_f) begin
                    n_fail++;
                    $display("FAIL stall_hold: out_valid=%b f=%h, required 1/%h",
                             bus32.out_valid, bus32.f, prev_f);
                end
            end
            bus32.out_ready = 1'($urandom_range(0, 1));
            if (sent < 100 && $urandom_range(0, 3) != 0) begin
                bus32.in_valid = 1'b1;
                bus32.a        = $urandom;
                bus32.b        = $urandom;
                bus32.cin      = 1'($urandom_range(0, 1));
                bus32.op_sub   = 1'($urandom_range(0, 1));
            end else begin
                bus32.in_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (bus32.in_ready !== !(bus32.out_valid && !bus32.out_ready)) begin
                n_fail++;
                $display("FAIL in_ready: got %b with out_valid=%b out_ready=%b",
                         bus32.in_ready, bus32.out_valid, bus32.out_ready);
            end
            if (bus32.out_valid && bus32.out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: got f=%h, required no beat", bus32.f);
                end else begin
                    exp = exp_q.pop_front();
                    if ({bus32.f, bus32.cout, bus32.ovf} !== {exp.f, exp.cout, exp.ovf}) begin
                        n_fail++;
                        $display("FAIL b2b_result[%0d]: got %h/%b/%b, required %h/%b/%b", recv,
                                 bus32.f, bus32.cout, bus32.ovf, exp.f, exp.cout, exp.ovf);
                    end
                end
                $display("b2b out[%0d] f=%h cout=%0d ovf=%0d", recv, bus32.f, bus32.cout, bus32.ovf);
                recv++;
            end
            if (bus32.in_valid && bus32.in_ready) begin
                exp_q.push_back(model(32, bus32.a, bus32.b, bus32.cin, bus32.op_sub));
                sent++;
            end
            prev_stall = bus32.out_valid && !bus32.out_ready;
            prev_f     = bus32.f;
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        n_checks++;
        if (recv != 100 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: received %0d pending %0d, required 100/0", recv, exp_q.size());
        end
        repeat (6) begin
            @(negedge clk);
            if (bus32.out_valid) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL b2b_duplicate: %0d extra beats, required 0", stray);
        end
    endtask

    task automatic test_reset_midstream;
        res_t got, exp;
        int   lat, stray = 0;
        logic [31:0] ra, rb;
        @(negedge clk);
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus32.in_valid = 1'b1;
            bus32.a = $urandom; bus32.b = $urandom; bus32.cin = 1'b0; bus32.op_sub = 1'b0;
            @(negedge clk);
        end
        bus32.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus32.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_valid: out_valid=%b, required 0", bus32.out_valid);
        end
        repeat (5) begin
            @(negedge clk);
            if (bus32.out_valid) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL midreset_stale: %0d stale beats, required 0", stray);
        end
        ra = $urandom; rb = $urandom;
        exp = model(32, ra, rb, 1'b1, 1'b1);
        op32(ra, rb, 1'b1, 1'b1, got, lat);
        n_checks++;
        if (got !== exp || lat !== 4) begin
            n_fail++;
            $display("FAIL midreset_next: got %h/%b/%b lat %0d, required %h/%b/%b lat 4",
                     got.f, got.cout, got.ovf, lat, exp.f, exp.cout, exp.ovf);
        end
    endtask

    task automatic test_seg8;
        res_t        got, exp;
        int          lat;
        logic [31:0] ra, rb;
        logic        rc, rs;
        op8(8'h80, 8'h80, 1'b0, 1'b0, got, lat);
        n_checks++;
        if (got !== '{f: 32'h0, cout: 1'b1, ovf: 1'b1} || lat !== 1) begin
            n_fail++;
            $display("FAIL seg8_basic: got %h/%b/%b lat %0d, required 00/1/1 lat 1",
                     got.f[7:0], got.cout, got.ovf, lat);
        end
        for (int i = 0; i < 8; i++) begin
            ra = 32'($urandom_range(0, 255));
            rb = 32'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            exp = model(8, ra, rb, rc, rs);
            op8(ra[7:0], rb[7:0], rc, rs, got, lat);
            n_checks++;
            if (got !== exp || lat !== 1) begin
                n_fail++;
                $display("FAIL seg8_rand[%0d]: got %h/%b/%b lat %0d, required %h/%b/%b lat 1",
                         i, got.f[7:0], got.cout, got.ovf, lat, exp.f[7:0], exp.cout, exp.ovf);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
        bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.op_sub = 1'b0;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
        bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.op_sub = 1'b0;

        test_reset();
        test_add();
        test_carry_ripple();
        test_sub();
        test_back_to_back();
        test_reset_midstream();
        test_seg8();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
